hazard_unit: RTL and testbench

- Pipeline stall/flush controller for the 5-stage MIPS core; counterpart to the forwarding logic.
- Forwarding resolves the hazards it can bypass. This block handles the remainder:
  - load-use stalls
  - ID-stage branch operand stalls
  - I/D memory waits
  - taken-branch flushes
  - halt drain
- Drives enable/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/hazard_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush controller; optional counters via HAZARD_STATS_EN
module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_branch,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regWr,
    input  logic             ex_memRd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_memRd,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             mem_halt,
`ifdef HAZARD_STATS_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count,
`endif
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic             stall_active
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic dep_ex;
    logic dep_mem;
    logic lu;
    logic be;
    logic bm;
    logic need_two;
    logic need_one;
    logic dw;
    logic bubble;
    logic branch_flush;

    // $zero is hardwired, so it never carries a real dependency
    assign dep_ex  = (ex_rd  != '0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt));
    assign dep_mem = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));

    assign lu = ex_memRd && dep_ex;
    assign be = id_branch && ex_regWr && dep_ex;
    assign bm = id_branch && mem_memRd && dep_mem;

    assign need_two = (state == RUN) && be && ex_memRd;
    assign need_one = (state == RUN) && (be || lu || bm);
    assign dw       = (mem_dREN || mem_dWEN) && !dhit;
    assign bubble   = need_one || (state == STALL);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_en     = 1'b1;
        memwb_flush  = 1'b0;
        branch_flush = 1'b0;
        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state == HALT) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (dw) begin
            // Whole front end freezes; a bubble drains into MEM/WB
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (bubble || !ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush   = 1'b1;
            branch_flush = 1'b1;
        end
    end

    assign stall_active = !pc_en;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
            cnt   <= '0;
            halt  <= 1'b0;
        end else begin
            halt <= (state == HALT);
            case (state)
                RUN: begin
                    if (mem_halt && !dw) begin
                        state <= HALT;
                    end else if (!dw && need_two) begin
                        state <= STALL;
                        cnt   <= CNT_W'(1);
                    end
                end
                STALL: begin
                    if (mem_halt && !dw) begin
                        state <= HALT;
                        cnt   <= '0;
                    end else if (!dw) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_active && (state != HALT) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed bench for hazard_unit
module tb_hazard_unit;

    logic       CLK;
    logic       nRST;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_branch, id_branch_taken, ex_regWr, ex_memRd, mem_memRd;
    logic       mem_dREN, mem_dWEN, dhit, ihit, mem_halt;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halt, stall_active;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST),
        .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .ex_rd(ex_rd), .ex_regWr(ex_regWr), .ex_memRd(ex_memRd),
        .mem_rd(mem_rd), .mem_memRd(mem_memRd), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .dhit(dhit), .ihit(ihit), .mem_halt(mem_halt),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .stall_active(stall_active)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_branch = 0; id_branch_taken = 0;
        ex_rd = 0; ex_regWr = 0; ex_memRd = 0;
        mem_rd = 0; mem_memRd = 0; mem_dREN = 0; mem_dWEN = 0;
        dhit = 0; ihit = 1; mem_halt = 0;
    endtask

    // advance one edge, then let inputs be changed away from the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_be(input logic load);
        id_branch = 1; id_rt = 5'd4; ex_rd = 5'd4; ex_regWr = 1; ex_memRd = load;
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        tick(); settle();
        check("rst_pc_en", pc_en, 0);
        check("rst_memwb_en", memwb_en, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_memwb_flush", memwb_flush, 1);
        check("rst_stall_active", stall_active, 1);
        check("rst_halt", halt, 0);
        check("rst_state", dut.state, 0);

        nRST = 1; settle();
        check("norm_pc_en", pc_en, 1);
        check("norm_idex_flush", idex_flush, 0);
        check("norm_stall_active", stall_active, 0);

        // load-use: one bubble
        ex_rd = 5'd3; ex_memRd = 1; id_rs = 5'd3; settle();
        check("lu_pc_en", pc_en, 0);
        check("lu_ifid_en", ifid_en, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_exmem_en", exmem_en, 1);
        tick(); clear_inputs(); settle();
        check("lu_after_pc_en", pc_en, 1);
        check("lu_after_state", dut.state, 0);

        // branch on load result: two bubbles
        set_be(1); settle();
        check("be2_c1_pc_en", pc_en, 0);
        check("be2_c1_idex_flush", idex_flush, 1);
        tick(); clear_inputs(); settle();
        check("be2_c2_state", dut.state, 1);
        check("be2_c2_cnt", dut.cnt, 1);
        check("be2_c2_pc_en", pc_en, 0);
        check("be2_c2_idex_flush", idex_flush, 1);
        tick(); settle();
        check("be2_c3_state", dut.state, 0);
        check("be2_c3_cnt", dut.cnt, 0);
        check("be2_c3_pc_en", pc_en, 1);

        // branch on ALU result: one bubble
        set_be(0); settle();
        check("be1_pc_en", pc_en, 0);
        tick(); clear_inputs(); settle();
        check("be1_after_pc_en", pc_en, 1);
        check("be1_after_state", dut.state, 0);

        // dmem wait during STALL freezes the counter
        set_be(1); tick(); clear_inputs();
        mem_dREN = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("dw_pc_en", pc_en, 0);
            check("dw_idex_en", idex_en, 0);
            check("dw_exmem_en", exmem_en, 0);
            check("dw_memwb_flush", memwb_flush, 1);
            check("dw_cnt", dut.cnt, 1);
            check("dw_state", dut.state, 1);
            tick();
        end
        dhit = 1; settle();
        check("dw_end_pc_en", pc_en, 0);
        check("dw_end_idex_flush", idex_flush, 1);
        check("dw_end_memwb_flush", memwb_flush, 0);
        check("dw_end_exmem_en", exmem_en, 1);
        tick(); clear_inputs(); settle();
        check("dw_done_state", dut.state, 0);
        check("dw_done_pc_en", pc_en, 1);

        // register 0 never creates a dependency
        ex_rd = 0; ex_memRd = 1; id_rs = 0; id_branch = 1; ex_regWr = 1; settle();
        check("zero_pc_en", pc_en, 1);
        check("zero_idex_flush", idex_flush, 0);
        clear_inputs();

        // MEM load feeding an ID branch: one bubble
        id_branch = 1; id_rs = 5'd7; mem_rd = 5'd7; mem_memRd = 1; settle();
        check("bm_pc_en", pc_en, 0);
        tick(); clear_inputs(); settle();
        check("bm_after_pc_en", pc_en, 1);

        // imem wait with a taken branch, then the flush
        id_branch_taken = 1; ihit = 0; settle();
        check("iw_pc_en", pc_en, 0);
        check("iw_ifid_en", ifid_en, 0);
        check("iw_ifid_flush", ifid_flush, 0);
        check("iw_idex_flush", idex_flush, 1);
        check("iw_memwb_en", memwb_en, 1);
        ihit = 1; settle();
        check("tb_ifid_flush", ifid_flush, 1);
        check("tb_pc_en", pc_en, 1);
        check("tb_idex_flush", idex_flush, 0);
        tick(); clear_inputs();

        // halt blocked by a dmem wait, then drains
        mem_halt = 1; mem_dREN = 1; dhit = 0; tick(); settle();
        check("halt_dw_state", dut.state, 0);
        dhit = 1; tick(); clear_inputs(); settle();
        check("halt_e1_state", dut.state, 2);
        check("halt_e1_flag", halt, 0);
        check("halt_e1_pc_en", pc_en, 0);
        tick(); settle();
        check("halt_e2_flag", halt, 1);
        for (int i = 0; i < 10; i++) begin
            id_branch_taken = 1;
            check("halt_pc_en", pc_en, 0);
            check("halt_ifid_flush", ifid_flush, 1);
            check("halt_idex_flush", idex_flush, 1);
            check("halt_exmem_flush", exmem_flush, 1);
            check("halt_memwb_en", memwb_en, 1);
            tick(); settle();
        end
        clear_inputs();
        nRST = 0; tick(); nRST = 1; settle();
        check("halt_rst_flag", halt, 0);
        check("halt_rst_state", dut.state, 0);
        check("halt_rst_pc_en", pc_en, 1);

        // reset in the middle of a two-bubble stall leaves no bubbles behind
        set_be(1); tick(); clear_inputs();
        nRST = 0; tick(); nRST = 1; settle();
        check("rst_stall_state", dut.state, 0);
        check("rst_stall_pc_en", pc_en, 1);

`ifdef HAZARD_STATS_EN
        nRST = 0; tick(); nRST = 1; settle();
        check("st_reset_cycles", stall_cycles, 0);
        check("st_reset_flushes", flush_count, 0);
        ex_rd = 5'd3; ex_memRd = 1; id_rs = 5'd3; tick(); clear_inputs();
        set_be(1); tick(); clear_inputs(); tick();
        mem_dREN = 1; dhit = 0; tick(); tick(); tick();
        clear_inputs(); settle();
        check("st_stall_cycles", stall_cycles, 6);
        id_branch_taken = 1; tick(); clear_inputs(); tick();
        id_branch_taken = 1; tick(); clear_inputs(); settle();
        check("st_flush_count", flush_count, 2);
        check("st_stall_unchanged", stall_cycles, 6);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
